// File: rtl/apb_iis_tx.sv
// APB-programmable Philips I2S transmitter: TX FIFO, programmable bit clock,
// stereo or mono-duplicate framing and a level/error interrupt.
module apb_iis_tx #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int SAMPLE_W       = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int DIV_W          = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]               pwdata,
  input  logic                      pwrite,
  input  logic                      psel,
  input  logic                      penable,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      i2s_sck_o,
  output logic                      i2s_ws_o,
  output logic                      i2s_sd_o,
  output logic                      int_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BC_W  = $clog2(2 * SAMPLE_W);

  localparam logic [BC_W-1:0]  BC_ZERO  = BC_W'(0);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(2 * SAMPLE_W - 1);
  localparam logic [BC_W-1:0]  BC_RIGHT = BC_W'(SAMPLE_W);
  localparam logic [BC_W-1:0]  BC_WS_LO = BC_W'(SAMPLE_W - 1);
  localparam logic [BC_W-1:0]  BC_WS_HI = BC_W'(2 * SAMPLE_W - 2);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // APB decode
  logic       access;
  logic       addr_err;
  logic       wr_en;
  logic [2:0] reg_idx;
  logic       wr_ctrl;
  logic       wr_div;
  logic       wr_tx;
  logic       wr_stat;
  logic       wr_irq;
  logic       flush;

  // control / status registers
  logic             en;
  logic             en_d;
  logic             mono;
  logic [DIV_W-1:0] div;
  logic             ovf;
  logic             unf;
  logic             ie_lvl;
  logic             ie_err;
  logic [LVL_W-1:0] thresh;

  // FIFO
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr;
  logic [PTR_W-1:0]    rptr;
  logic [LVL_W-1:0]    level;
  logic                full;
  logic                empty;
  logic                push_ok;
  logic                pop_ok;
  logic [SAMPLE_W-1:0] pop_data;

  // serialiser
  logic [DIV_W-1:0]    dc;
  logic [DIV_W-1:0]    div_act;
  logic [BC_W-1:0]     bc;
  logic [BC_W-1:0]     nbc;
  logic [SAMPLE_W-1:0] sr;
  logic [SAMPLE_W-1:0] last_left;
  logic                sck;
  logic                ws;
  logic                sd;
  logic                tick;
  logic                start;
  logic                fall;
  logic                pop_pt;
  logic                mono_rl;

  logic unused_bits;

  assign access   = psel & penable;
  assign addr_err = (paddr >= APB_ADDR_WIDTH'(32'h14));
  assign wr_en    = access & pwrite & ~addr_err;
  assign reg_idx  = paddr[4:2];
  assign wr_ctrl  = wr_en & (reg_idx == 3'd0);
  assign wr_div   = wr_en & (reg_idx == 3'd1);
  assign wr_tx    = wr_en & (reg_idx == 3'd2);
  assign wr_stat  = wr_en & (reg_idx == 3'd3);
  assign wr_irq   = wr_en & (reg_idx == 3'd4);
  assign flush    = wr_ctrl & pwdata[2];

  assign pready  = 1'b1;
  assign pslverr = access & addr_err;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == LVL_ZERO);
  // An overflowing push is dropped even if a pop frees a slot in the same cycle.
  assign push_ok = wr_tx & ~full & ~flush;
  assign pop_ok  = pop_pt & ~empty & ~flush;

  assign tick    = (dc == div_act);
  assign start   = en & ~en_d;
  assign fall    = en & en_d & tick & sck;
  assign pop_pt  = start | (fall & ((nbc == BC_ZERO) | ((nbc == BC_RIGHT) & ~mono)));
  assign mono_rl = fall & (nbc == BC_RIGHT) & mono;

  assign i2s_sck_o = sck;
  assign i2s_ws_o  = ws;
  assign i2s_sd_o  = sd;

  assign unused_bits = ^{pwdata, paddr, sr[SAMPLE_W-1]};

  // next bit-counter value, wrapping at the end of the stereo frame
  always_comb begin
    if (bc == BC_LAST) begin
      nbc = BC_ZERO;
    end else begin
      nbc = bc + BC_W'(1);
    end
  end

  // sample presented at a pop point; an empty FIFO supplies silence
  always_comb begin
    if (empty) begin
      pop_data = {SAMPLE_W{1'b0}};
    end else begin
      pop_data = mem[rptr];
    end
  end

  // register read mux
  always_comb begin
    prdata = 32'h0000_0000;
    if (addr_err) begin
      prdata = 32'h0000_0000;
    end else begin
      case (reg_idx)
        3'd0: prdata[1:0] = {mono, en};
        3'd1: prdata[DIV_W-1:0] = div;
        3'd3: begin
          prdata[3:0]        = {unf, ovf, empty, full};
          prdata[8 +: LVL_W] = level;
        end
        3'd4: begin
          prdata[1:0]        = {ie_err, ie_lvl};
          prdata[8 +: LVL_W] = thresh;
        end
        default: prdata = 32'h0000_0000;
      endcase
    end
  end

  // control/status registers, FIFO pointers and the interrupt
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      en     <= 1'b0;
      mono   <= 1'b0;
      div    <= {DIV_W{1'b0}};
      ovf    <= 1'b0;
      unf    <= 1'b0;
      ie_lvl <= 1'b0;
      ie_err <= 1'b0;
      thresh <= LVL_ZERO;
      wptr   <= PTR_W'(0);
      rptr   <= PTR_W'(0);
      level  <= LVL_ZERO;
      int_o  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en   <= pwdata[0];
        mono <= pwdata[1];
      end
      if (wr_div) begin
        div <= pwdata[DIV_W-1:0];
      end
      if (wr_irq) begin
        ie_lvl <= pwdata[0];
        ie_err <= pwdata[1];
        thresh <= pwdata[8 +: LVL_W];
      end
      if (wr_tx & full) begin
        ovf <= 1'b1;
      end else if (wr_stat & pwdata[2]) begin
        ovf <= 1'b0;
      end
      if (pop_pt & empty) begin
        unf <= 1'b1;
      end else if (wr_stat & pwdata[3]) begin
        unf <= 1'b0;
      end
      if (flush) begin
        wptr  <= PTR_W'(0);
        rptr  <= PTR_W'(0);
        level <= LVL_ZERO;
      end else begin
        if (push_ok) begin
          wptr <= wptr + PTR_W'(1);
        end
        if (pop_ok) begin
          rptr <= rptr + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end
      int_o <= (ie_lvl & en & (level <= thresh)) | (ie_err & (ovf | unf));
    end
  end

  // FIFO storage; occupancy is tracked by level, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wptr] <= pwdata[SAMPLE_W-1:0];
    end
  end

  // bit-clock divider and MSB-first shifter
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      en_d      <= 1'b0;
      dc        <= {DIV_W{1'b0}};
      div_act   <= {DIV_W{1'b0}};
      bc        <= BC_ZERO;
      sr        <= {SAMPLE_W{1'b0}};
      last_left <= {SAMPLE_W{1'b0}};
      sck       <= 1'b0;
      ws        <= 1'b0;
      sd        <= 1'b0;
    end else begin
      en_d <= en;
      if (!en) begin
        dc      <= {DIV_W{1'b0}};
        div_act <= div;
        bc      <= BC_ZERO;
        sck     <= 1'b0;
        ws      <= 1'b0;
        sd      <= 1'b0;
      end else begin
        // a new divisor is only adopted at a wrap, so half-periods are never cut short
        if (tick) begin
          dc      <= {DIV_W{1'b0}};
          sck     <= ~sck;
          div_act <= div;
        end else begin
          dc <= dc + DIV_W'(1);
        end
        if (start) begin
          bc        <= BC_ZERO;
          ws        <= 1'b0;
          sr        <= pop_data;
          last_left <= pop_data;
          sd        <= pop_data[SAMPLE_W-1];
        end else if (fall) begin
          bc <= nbc;
          ws <= (nbc >= BC_WS_LO) && (nbc <= BC_WS_HI);
          if (pop_pt) begin
            sr <= pop_data;
            sd <= pop_data[SAMPLE_W-1];
            if (nbc == BC_ZERO) begin
              last_left <= pop_data;
            end
          end else if (mono_rl) begin
            sr <= last_left;
            sd <= last_left[SAMPLE_W-1];
          end else begin
            sr <= {sr[SAMPLE_W-2:0], 1'b0};
            sd <= sr[SAMPLE_W-2];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_iis_tx.sv
// Bench for apb_iis_tx: APB register stimulus plus a scoreboard of expected
// {WS, SD} bits checked at every rising SCK edge.
module tb_apb_iis_tx;

  localparam int W = 16;
  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_DIV  = 12'h004;
  localparam logic [11:0] A_TX   = 12'h008;
  localparam logic [11:0] A_STAT = 12'h00C;
  localparam logic [11:0] A_IRQ  = 12'h010;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        i2s_sck_o;
  logic        i2s_ws_o;
  logic        i2s_sd_o;
  logic        int_o;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q [$];
  int   cyc = 0;
  int   last_rise = 0;
  int   period = 0;
  logic sck_prev = 1'b0;

  always #5 clk_i = ~clk_i;

  apb_iis_tx #(
    .APB_ADDR_WIDTH(12),
    .SAMPLE_W(16),
    .FIFO_DEPTH(8),
    .DIV_W(8)
  ) dut (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .paddr(paddr),
    .pwdata(pwdata),
    .pwrite(pwrite),
    .psel(psel),
    .penable(penable),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr),
    .i2s_sck_o(i2s_sck_o),
    .i2s_ws_o(i2s_ws_o),
    .i2s_sd_o(i2s_sd_o),
    .int_o(int_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every rising SCK edge consumes one expected {ws, sd}
  always @(negedge clk_i) begin
    cyc      <= cyc + 1;
    sck_prev <= i2s_sck_o;
    if (i2s_sck_o && !sck_prev) begin
      period    <= cyc - last_rise;
      last_rise <= cyc;
      if (exp_q.size() > 0) begin
        check("sd_bit", 32'(i2s_sd_o), 32'(exp_q[0][0]));
        check("ws_bit", 32'(i2s_ws_o), 32'(exp_q[0][1]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk_i);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge clk_i);
    penable = 1'b1;
    @(negedge clk_i);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    @(negedge clk_i);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge clk_i);
    penable = 1'b1;
    #1;
    d   = prdata;
    err = pslverr;
    @(negedge clk_i);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    check(tag, d, exp);
  endtask

  // one stereo frame: left word then right word, MSB first, WS leading by one bit
  task automatic exp_frame(input logic [15:0] l, input logic [15:0] r);
    for (int k = 0; k < 2 * W; k++) begin
      logic b;
      logic w;
      b = (k < W) ? l[W-1-k] : r[2*W-1-k];
      w = (k >= W - 1 && k <= 2 * W - 2) ? 1'b1 : 1'b0;
      exp_q.push_back({w, b});
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 6000 && exp_q.size() > 0; i++) @(negedge clk_i);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic half_period(output int n);
    logic s;
    s = i2s_sck_o;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (i2s_sck_o == s && n < 50);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check("rst_sck", 32'(i2s_sck_o), 32'd0);
    check("rst_ws", 32'(i2s_ws_o), 32'd0);
    check("rst_sd", 32'(i2s_sd_o), 32'd0);
    check("rst_int", 32'(int_o), 32'd0);
    check("rst_slverr", 32'(pslverr), 32'd0);
    check("rst_pready", 32'(pready), 32'd1);
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          n;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h000; pwdata = 32'h0;

    do_reset();
    read_check("rst_status", A_STAT, 32'h0000_0002);
    read_check("rst_ctrl", A_CTRL, 32'h0);
    read_check("rst_irq", A_IRQ, 32'h0);

    // stereo, d=1
    apb_write(A_DIV, 32'd1);
    apb_write(A_TX, 32'h0000_A5A5);
    apb_write(A_TX, 32'h0000_3C3C);
    exp_frame(16'hA5A5, 16'h3C3C);
    exp_frame(16'h0000, 16'h0000);
    read_check("st_level", A_STAT, 32'h0000_0200);
    apb_write(A_CTRL, 32'h1);
    n = 0;
    while (!i2s_sck_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("st_first_rise", 32'(n), 32'd2);
    wait_drain("st_drain");
    check("st_period", 32'(period), 32'd4);
    check("st_sd_idle", 32'(i2s_sd_o), 32'd0);
    read_check("st_unf", A_STAT, 32'h0000_000A);
    apb_write(A_CTRL, 32'h0);
    @(negedge clk_i);
    check("off_sck", 32'(i2s_sck_o), 32'd0);
    check("off_ws", 32'(i2s_ws_o), 32'd0);
    check("off_sd", 32'(i2s_sd_o), 32'd0);
    read_check("off_sticky", A_STAT, 32'h0000_000A);
    apb_write(A_STAT, 32'h8);
    read_check("unf_clr", A_STAT, 32'h0000_0002);

    // mono duplicate
    apb_write(A_CTRL, 32'h2);
    apb_write(A_TX, 32'h0000_8001);
    apb_write(A_TX, 32'h0000_4002);
    exp_frame(16'h8001, 16'h8001);
    exp_frame(16'h4002, 16'h4002);
    exp_frame(16'h0000, 16'h0000);
    apb_write(A_CTRL, 32'h3);
    read_check("mono_ctrl", A_CTRL, 32'h3);
    read_check("mono_lvl1", A_STAT, 32'h0000_0100);
    for (int i = 0; i < 2000 && exp_q.size() > 48; i++) @(negedge clk_i);
    read_check("mono_lvl0", A_STAT, 32'h0000_0002);
    wait_drain("mono_drain");
    read_check("mono_unf", A_STAT, 32'h0000_000A);
    apb_write(A_CTRL, 32'h0);

    // overflow: 9 pushes into depth 8, 9th never sent
    do_reset();
    for (int i = 0; i < 9; i++) apb_write(A_TX, 32'h1111 * (i + 1));
    read_check("ovf_status", A_STAT, 32'h0000_0805);
    apb_write(A_STAT, 32'h4);
    read_check("ovf_clr", A_STAT, 32'h0000_0801);
    for (int i = 0; i < 4; i++) exp_frame(16'(32'h1111 * (2 * i + 1)), 16'(32'h1111 * (2 * i + 2)));
    exp_frame(16'h0000, 16'h0000);
    apb_write(A_CTRL, 32'h1);
    wait_drain("ovf_drain");
    apb_write(A_CTRL, 32'h0);

    // level interrupt
    do_reset();
    apb_write(A_DIV, 32'd1);
    apb_write(A_IRQ, 32'h0000_0201);
    for (int i = 0; i < 4; i++) apb_write(A_TX, 32'h0000_0F0F);
    check("irq_idle", 32'(int_o), 32'd0);
    apb_write(A_CTRL, 32'h1);
    n = 0;
    while (!int_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("irq_rise", 32'(n), 32'd65);
    read_check("irq_lvl", A_STAT, 32'h0000_0200);
    apb_write(A_CTRL, 32'h0);
    check("irq_hold", 32'(int_o), 32'd1);
    @(negedge clk_i);
    check("irq_drop", 32'(int_o), 32'd0);

    // error interrupt from overflow
    apb_write(A_IRQ, 32'h2);
    for (int i = 0; i < 7; i++) apb_write(A_TX, 32'h0000_0001);
    @(negedge clk_i);
    check("irq_err", 32'(int_o), 32'd1);
    apb_write(A_STAT, 32'h4);
    @(negedge clk_i);
    check("irq_err_clr", 32'(int_o), 32'd0);

    // flush
    do_reset();
    for (int i = 0; i < 5; i++) apb_write(A_TX, 32'h0000_00AA);
    read_check("fl_lvl5", A_STAT, 32'h0000_0500);
    apb_write(A_CTRL, 32'h4);
    read_check("fl_status", A_STAT, 32'h0000_0002);
    read_check("fl_ctrl", A_CTRL, 32'h0);
    apb_write(A_TX, 32'h0000_0055);
    read_check("fl_push", A_STAT, 32'h0000_0100);

    // out-of-range address
    apb_read(12'h014, d, e);
    check("slverr_14", 32'(e), 32'd1);
    check("slverr_data", d, 32'h0);
    apb_read(A_IRQ, d, e);
    check("slverr_10", 32'(e), 32'd0);
    check("slverr_idle", 32'(pslverr), 32'd0);

    // divider change mid-frame
    do_reset();
    apb_write(A_CTRL, 32'h1);
    half_period(n);
    half_period(n);
    check("div0_half", 32'(n), 32'd1);
    apb_write(A_DIV, 32'd3);
    half_period(n);
    half_period(n);
    check("div3_half_a", 32'(n), 32'd4);
    half_period(n);
    check("div3_half_b", 32'(n), 32'd4);
    read_check("div_rd", A_DIV, 32'h3);
    apb_write(A_CTRL, 32'h0);

    // reset in the middle of a frame
    do_reset();
    apb_write(A_DIV, 32'd1);
    apb_write(A_IRQ, 32'h0000_0801);
    apb_write(A_TX, 32'h0000_FFFF);
    apb_write(A_TX, 32'h0000_FFFF);
    apb_write(A_CTRL, 32'h1);
    n = 0;
    while (!i2s_ws_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("mid_ws", 32'(i2s_ws_o), 32'd1);
    check("mid_int", 32'(int_o), 32'd1);
    do_reset();
    read_check("mid_status", A_STAT, 32'h0000_0002);
    read_check("mid_ctrl", A_CTRL, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
